// File: rtl/vending_pkg.sv
// Shared types and coin helpers for the parametrised vending controller family.
package vending_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    CHANGE  = 1'b1
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  // Coin value in 5-cent units.
  function automatic logic [2:0] coin_units(input logic [1:0] coin);
    logic [2:0] units;
    case (coin)
      COIN_5:  units = 3'd1;
      COIN_10: units = 3'd2;
      COIN_25: units = 3'd5;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vending_change_gen.sv
// Greedy change-coin selector: picks the largest allowed coin not exceeding the remaining amount.
module vending_change_gen
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] remaining,
  input  logic                chg10_en,
  output logic [1:0]          chg_coin_c,
  output logic [1:0]          dec_c
);

  always_comb begin
    chg_coin_c = COIN_5;
    dec_c      = 2'd1;
    if (chg10_en && (remaining >= CREDIT_W'(2))) begin
      chg_coin_c = COIN_10;
      dec_c      = 2'd2;
    end
  end

endmodule

// File: rtl/vending_ctrl_param.sv
// Parametrised-price vending controller: collects 5/10/25 coins, vends with a Mealy pulse,
// and returns change or a cancelled credit as a valid/ready stream of 5/10-cent coins.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int unsigned PRICE_U  = 4,
  parameter int unsigned CHG10_EN = 1,
  parameter int unsigned CREDIT_W = $clog2(PRICE_U + 5)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic                dispense,
  output logic                coin_reject,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_U);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] sum;
  logic                chg_valid_q, chg_valid_d;
  logic                busy_q, busy_d;
  logic [1:0]          chg_coin_q, chg_coin_d;
  logic [1:0]          chg_dec_q, chg_dec_d;
  logic [1:0]          gen_coin, gen_dec;
  logic                dispense_c, coin_reject_c;

  // Coin choice is made from the amount that will be outstanding next cycle, then held.
  vending_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .remaining  (credit_d),
    .chg10_en   (1'(CHG10_EN)),
    .chg_coin_c (gen_coin),
    .dec_c      (gen_dec)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    dispense_c    = 1'b0;
    coin_reject_c = 1'b0;
    sum           = credit_q + CREDIT_W'(coin_units(coin));
    case (state_q)
      COLLECT: begin
        if (cancel) begin
          coin_reject_c = (coin != COIN_NONE);
          if (credit_q != '0) state_d = CHANGE;
        end else if (sum >= PRICE_C) begin
          dispense_c = 1'b1;
          credit_d   = sum - PRICE_C;
          if (credit_d != '0) state_d = CHANGE;
        end else begin
          credit_d = sum;
        end
      end
      CHANGE: begin
        coin_reject_c = (coin != COIN_NONE);
        if (chg_ready) begin
          credit_d = credit_q - CREDIT_W'(chg_dec_q);
          if (credit_d == '0) state_d = COLLECT;
        end
      end
      default: begin
        state_d  = COLLECT;
        credit_d = '0;
      end
    endcase
    chg_valid_d = (state_d == CHANGE);
    busy_d      = (state_d == CHANGE);
    chg_coin_d  = (state_d == CHANGE) ? gen_coin : COIN_NONE;
    chg_dec_d   = gen_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      credit_q    <= '0;
      chg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      chg_coin_q  <= COIN_NONE;
      chg_dec_q   <= 2'd1;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      chg_valid_q <= chg_valid_d;
      busy_q      <= busy_d;
      chg_coin_q  <= chg_coin_d;
      chg_dec_q   <= chg_dec_d;
    end
  end

  // Mealy pulses are suppressed while reset is held.
  assign dispense    = dispense_c & ~rst;
  assign coin_reject = coin_reject_c & ~rst;
  assign chg_valid   = chg_valid_q;
  assign chg_coin    = chg_coin_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule
